// File: rtl/steamer_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter for the STEAMER16X4 core (M0) and a video/DMA engine (M1).
// Registered grant with beat-quantum preemption and a bus watchdog that turns a hung slave into a fault.
module steamer_bus_arbiter #(
  parameter int QUANTUM = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic [14:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic [1:0]  m0_stb_i,
  input  logic        m0_vda_i,
  input  logic        m0_vpa_i,
  input  logic [15:0] m0_dat_i,
  output logic        m0_ack_o,
  input  logic [14:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic [1:0]  m1_stb_i,
  input  logic [15:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [15:0] m_dat_o,
  output logic [14:0] s_adr_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic [1:0]  s_stb_o,
  output logic        s_vda_o,
  output logic        s_vpa_o,
  output logic [15:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [15:0] s_dat_i,
  output logic [1:0]  gnt_o,
  output logic        fault_o,
  output logic        fault_m_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [7:0] QMAX    = 8'(QUANTUM);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     nxt;
  logic       last;
  logic [7:0] beat;
  logic [7:0] beat_inc;
  logic [7:0] wd;
  logic       wd_stall;
  logic       wd_fire;
  logic       ack_eff;
  logic       quantum_hit;

  // Slave side is a pure mux of the granted master; gnt_o == 00 forces everything to zero.
  always_comb begin
    s_adr_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 2'b00;
    s_vda_o = 1'b0;
    s_vpa_o = 1'b0;
    s_dat_o = '0;
    if (gnt_o[0]) begin
      s_adr_o = m0_adr_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_vda_o = m0_vda_i;
      s_vpa_o = m0_vpa_i;
      s_dat_o = m0_dat_i;
    end else if (gnt_o[1]) begin
      s_adr_o = m1_adr_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_vda_o = 1'b1;
      s_vpa_o = 1'b0;
      s_dat_o = m1_dat_i;
    end
  end

  assign wd_stall    = s_cyc_o & (|s_stb_o) & ~s_ack_i;
  assign wd_fire     = wd_stall & (wd == WD_LAST);
  assign ack_eff     = (s_ack_i | wd_fire) & (|gnt_o);
  assign beat_inc    = (beat == QMAX) ? beat : beat + 8'd1;
  assign quantum_hit = ack_eff & (beat_inc == QMAX);

  assign m0_ack_o = ack_eff & gnt_o[0] & m0_cyc_i;
  assign m1_ack_o = ack_eff & gnt_o[1] & m1_cyc_i;
  assign m_dat_o  = (|gnt_o) ? (wd_fire ? 16'hFFFF : s_dat_i) : 16'h0000;

  // A holder leaves on dropping cyc, or on the ack that exhausts its quantum while the other waits.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last)) nxt = GNT0;
        else if (m1_cyc_i)                   nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i || (quantum_hit && m1_cyc_i)) nxt = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i || (quantum_hit && m0_cyc_i)) nxt = m0_cyc_i ? GNT0 : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state     <= IDLE;
      gnt_o     <= 2'b00;
      last      <= 1'b1;
      beat      <= 8'd0;
      wd        <= 8'd0;
      fault_o   <= 1'b0;
      fault_m_o <= 1'b0;
    end else begin
      state <= nxt;
      gnt_o <= (nxt == GNT0) ? 2'b01 : (nxt == GNT1) ? 2'b10 : 2'b00;
      if (state == GNT0 && nxt != GNT0) last <= 1'b0;
      if (state == GNT1 && nxt != GNT1) last <= 1'b1;
      if (nxt != state) begin
        beat <= 8'd0;
        wd   <= 8'd0;
      end else begin
        if (ack_eff) beat <= beat_inc;
        if (ack_eff)       wd <= 8'd0;
        else if (wd_stall) wd <= wd + 8'd1;
      end
      if (wd_fire) begin
        fault_o   <= 1'b1;
        fault_m_o <= gnt_o[1];
      end
    end
  end

endmodule

// File: tb/tb_steamer_bus_arbiter.sv
// Bench for steamer_bus_arbiter: scripted master scenarios against a behavioural slave,
// with read data checked through per-master expected queues.
module tb_steamer_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] m0_adr, m1_adr, s_adr;
  logic        m0_we, m0_cyc, m0_vda, m0_vpa, m0_ack;
  logic        m1_we, m1_cyc, m1_ack;
  logic [1:0]  m0_stb, m1_stb, s_stb, gnt;
  logic [15:0] m0_dat, m1_dat, m_dat, s_dat_out, s_dat_in;
  logic        s_we, s_cyc, s_vda, s_vpa, s_ack, fault, fault_m;

  int          checks = 0;
  int          failures = 0;
  int          m0_acks = 0;
  int          m1_acks = 0;
  int          slave_mode = 0;  // 0: ack one cycle after stb, 1: ack every cycle, 2: never ack
  logic        ack_wait = 1'b0;
  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];

  always #5 clk = ~clk;

  steamer_bus_arbiter dut (
    .clk_i(clk), .res_i(rst),
    .m0_adr_i(m0_adr), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_vda_i(m0_vda), .m0_vpa_i(m0_vpa), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack),
    .m1_adr_i(m1_adr), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_dat_i(m1_dat), .m1_ack_o(m1_ack),
    .m_dat_o(m_dat), .s_adr_o(s_adr), .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_vda_o(s_vda), .s_vpa_o(s_vpa), .s_dat_o(s_dat_out), .s_ack_i(s_ack), .s_dat_i(s_dat_in),
    .gnt_o(gnt), .fault_o(fault), .fault_m_o(fault_m)
  );

  // Slave model: read data is a fixed function of the address and never equals FFFF.
  function automatic logic [15:0] slave_data(input logic [14:0] a);
    return {1'b0, a} ^ 16'h1234;
  endfunction

  assign s_dat_in = slave_data(s_adr);
  assign s_ack = s_cyc && (s_stb != 2'b00) &&
                 ((slave_mode == 1) || ((slave_mode == 0) && ack_wait));
  always @(posedge clk) ack_wait <= s_cyc && (s_stb != 2'b00) && !s_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every master ack pops one expected read word.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m0_ack === 1'b1) begin
        m0_acks++;
        check_eq("m0_ack_expected", exp0_q.size() > 0, 1);
        if (exp0_q.size() > 0) check_eq("m0_rdata", m_dat, exp0_q.pop_front());
      end
      if (m1_ack === 1'b1) begin
        m1_acks++;
        check_eq("m1_ack_expected", exp1_q.size() > 0, 1);
        if (exp1_q.size() > 0) check_eq("m1_rdata", m_dat, exp1_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic [14:0] adr, input logic we,
                          input logic [1:0] stb, input logic [15:0] dat,
                          input logic vda, input logic vpa);
    m0_cyc = cyc; m0_adr = adr; m0_we = we; m0_stb = stb; m0_dat = dat;
    m0_vda = vda; m0_vpa = vpa;
  endtask

  task automatic drive_m1(input logic cyc, input logic [14:0] adr, input logic we,
                          input logic [1:0] stb, input logic [15:0] dat);
    m1_cyc = cyc; m1_adr = adr; m1_we = we; m1_stb = stb; m1_dat = dat;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive_m0(0, 0, 0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);
    slave_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m0_acks = 0;
    m1_acks = 0;
  endtask

  task automatic wait_acks(input int m, input int target, input int budget, input string tag);
    int n = 0;
    while (((m == 0) ? m0_acks : m1_acks) < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, ((m == 0) ? m0_acks : m1_acks) >= target, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [14:0] a0, a1;
    logic [15:0] d;
    logic        we, seen;
    logic [1:0]  stb;
    int          m, cnt, target;

    // Reset state, with M0 presenting vda/vpa but no cycle.
    do_reset();
    drive_m0(0, 15'h1234, 0, 0, 0, 1, 1);
    tick();
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_s_cyc", s_cyc, 0);
    check_eq("rst_s_adr", s_adr, 0);
    check_eq("rst_m_dat", m_dat, 0);
    check_eq("idle_vda", s_vda, 0);
    check_eq("idle_vpa", s_vpa, 0);
    check_eq("rst_fault", {fault, fault_m}, 2'b00);

    // M0 alone: one cycle of arbitration latency, then a single read.
    a0 = 15'($urandom_range(0, 32767));
    exp0_q.push_back(slave_data(a0));
    @(posedge clk); #1 drive_m0(1, a0, 0, 2'b11, 0, 1, 0);
    tick();
    check_eq("t1_latency_cyc", s_cyc, 0);
    tick();
    check_eq("t1_gnt", gnt, 2'b01);
    check_eq("t1_s_adr", s_adr, a0);
    check_eq("t1_vda_vpa", {s_vda, s_vpa}, 2'b10);
    wait_acks(0, 1, 10, "t1_m0_ack");
    check_eq("t1_m1_noack", m1_acks, 0);
    @(posedge clk); #1 drive_m0(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_eq("t1_idle", gnt, 2'b00);

    // Tie after reset goes to M0; M0 release hands straight to M1.
    do_reset();
    a0 = 15'($urandom_range(0, 32767));
    a1 = 15'($urandom_range(0, 32767));
    exp0_q.push_back(slave_data(a0));
    exp1_q.push_back(slave_data(a1));
    @(posedge clk); #1 drive_m0(1, a0, 0, 2'b11, 0, 1, 0); drive_m1(1, a1, 0, 2'b11, 0);
    tick(); tick();
    check_eq("t2_tie_m0", gnt, 2'b01);
    wait_acks(0, 1, 10, "t2_m0_ack");
    @(posedge clk); #1 drive_m0(0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    check_eq("t2_no_gap", gnt, 2'b10);
    check_eq("t2_m1_vda_vpa", {s_vda, s_vpa}, 2'b10);
    check_eq("t2_m1_adr", s_adr, a1);
    wait_acks(1, 1, 10, "t2_m1_ack");
    @(posedge clk); #1 drive_m1(0, 0, 0, 0, 0);
    tick(); tick();
    check_eq("t2_idle", gnt, 2'b00);

    // Quantum preemption with the slave acking every cycle.
    do_reset();
    slave_mode = 1;
    a0 = 15'($urandom_range(0, 32767));
    a1 = 15'($urandom_range(0, 32767));
    repeat (8) exp0_q.push_back(slave_data(a0));
    repeat (3) exp1_q.push_back(slave_data(a1));
    @(posedge clk); #1 drive_m0(1, a0, 0, 2'b11, 0, 1, 0); drive_m1(1, a1, 0, 2'b11, 0);
    wait_acks(0, 8, 30, "t3_m0_eight");
    tick();
    check_eq("t3_preempt_gnt", gnt, 2'b10);
    check_eq("t3_m0_stall", m0_ack, 0);
    wait_acks(1, 3, 20, "t3_m1_acks");
    check_eq("t3_m0_count", m0_acks, 8);
    repeat (2) exp0_q.push_back(slave_data(a0));
    @(posedge clk); #1 drive_m1(0, 0, 0, 0, 0);
    wait_acks(0, 10, 20, "t3_m0_regrant");
    @(posedge clk); #1 drive_m0(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_eq("t3_idle", gnt, 2'b00);

    // Watchdog on a hung M1 read.
    do_reset();
    slave_mode = 2;
    a1 = 15'($urandom_range(0, 32767));
    exp1_q.push_back(16'hFFFF);
    @(posedge clk); #1 drive_m1(1, a1, 0, 2'b11, 0);
    tick();
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 300) begin
      tick();
      cnt++;
      seen = m1_ack;
    end
    check_eq("t4_wd_cycle", cnt, 255);
    check_eq("t4_fault_pre", fault, 0);
    @(posedge clk); #1 drive_m1(0, 0, 0, 0, 0);
    tick();
    check_eq("t4_fault", {fault, fault_m}, 2'b11);
    repeat (5) tick();
    check_eq("t4_fault_sticky", fault, 1);
    check_eq("t4_m0_noack", m0_acks, 0);

    // Asynchronous reset while M1 holds a stalled beat.
    do_reset();
    slave_mode = 2;
    @(posedge clk); #1 drive_m1(1, 15'h0abc, 0, 2'b11, 0);
    tick(); tick();
    check_eq("t5_gnt1", gnt, 2'b10);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("t5_async_gnt", gnt, 2'b00);
    check_eq("t5_async_cyc", s_cyc, 0);
    check_eq("t5_async_acks", {m0_ack, m1_ack}, 2'b00);
    drive_m0(1, 15'h0123, 0, 2'b11, 0, 1, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick(); tick();
    check_eq("t5_tie_m0", gnt, 2'b01);
    drive_m0(0, 0, 0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);

    // Random single transfers from either master.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      m   = $urandom_range(0, 1);
      a0  = 15'($urandom_range(0, 32767));
      d   = 16'($urandom_range(0, 65535));
      we  = 1'($urandom_range(0, 1));
      stb = 2'($urandom_range(1, 3));
      target = ((m == 0) ? m0_acks : m1_acks) + 1;
      if (m == 0) exp0_q.push_back(slave_data(a0));
      else        exp1_q.push_back(slave_data(a0));
      @(posedge clk); #1;
      if (m == 0) drive_m0(1, a0, we, stb, d, 0, 1);
      else        drive_m1(1, a0, we, stb, d);
      tick(); tick();
      check_eq("t7_gnt", gnt, (m == 0) ? 2'b01 : 2'b10);
      check_eq("t7_bus", {s_adr, s_we, s_stb, s_dat_out}, {a0, we, stb, d});
      check_eq("t7_vda_vpa", {s_vda, s_vpa}, (m == 0) ? 2'b01 : 2'b10);
      wait_acks(m, target, 10, "t7_ack");
      @(posedge clk); #1;
      drive_m0(0, 0, 0, 0, 0, 0, 0);
      drive_m1(0, 0, 0, 0, 0);
      tick(); tick();
    end

    check_eq("q0_empty", exp0_q.size(), 0);
    check_eq("q1_empty", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
